// File: rtl/twiddle_gen_seq.sv
// Sequential twiddle generator: BASE^brv(k) mod Q by square-and-multiply
// on one shared multiplier/reducer, valid/ready on both sides.
module twiddle_gen_seq #(
  parameter int Q        = 3329,
  parameter int ZETA     = 17,
  parameter int ZETA_INV = 1175,
  parameter int LOGN     = 7,
  parameter int W        = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGN-1:0] in_index,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_phi,
  output logic [LOGN-1:0] out_index,
  output logic            busy
);

  localparam int CW = (LOGN > 1) ? $clog2(LOGN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQR  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2*W-1:0] PQ   = (2*W)'(Q);
  localparam logic [W-1:0]   BFWD = W'(ZETA);
  localparam logic [W-1:0]   BINV = W'(ZETA_INV);

  if ((2 ** W) <= Q) begin : g_bad_w
    $error("twiddle_gen_seq: 2**W must exceed Q");
  end

  logic [1:0]      state;
  logic [W-1:0]    acc;
  logic [W-1:0]    base;
  logic [LOGN-1:0] e;
  logic [LOGN-1:0] idx;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    opb;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    red;
  logic            ebit;

  function automatic logic [LOGN-1:0] brv(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = k[LOGN-1-i];
    return r;
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_SQR) || (state == S_MUL);
  assign ebit     = e[cnt];

  // One multiplier: squares in SQR, multiplies by base in MUL.
  always_comb begin
    opb  = (state == S_SQR) ? acc : base;
    prod = {{W{1'b0}}, acc} * {{W{1'b0}}, opb};
    red  = W'(prod % PQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= W'(1);
      base      <= '0;
      e         <= '0;
      idx       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_phi   <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            e     <= brv(in_index);
            base  <= in_inv ? BINV : BFWD;
            idx   <= in_index;
            acc   <= W'(1);
            cnt   <= CW'(LOGN - 1);
            state <= S_SQR;
          end
        end
        S_SQR: begin
          acc   <= red;
          state <= S_MUL;
        end
        S_MUL: begin
          if (ebit) acc <= red;
          if (cnt == '0) begin
            out_phi   <= ebit ? red : acc;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt   <= cnt - CW'(1);
            state <= S_SQR;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
